// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds byte-stream clients, one packet at a time, into a single UART transmitter.
// Optional grant watchdog is enabled with macro UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int NCLI           = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCLI-1:0]     req_valid,
  input  logic [8*NCLI-1:0]   req_data,
  input  logic [NCLI-1:0]     req_last,
  output logic [NCLI-1:0]     req_ready,
  output logic [NCLI-1:0]     grant,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  input  logic                tx_busy,
  output logic                timeout_err
);

  localparam int PW = (NCLI > 1) ? $clog2(NCLI) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic            lock, lock_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [7:0]      data_q, data_nxt;
  logic [PW-1:0]   pick;
  logic            pick_vld;
  logic            take;
  logic            to_fire;

  // While locked only the owner is a candidate; otherwise scan from rr_ptr+1.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    pick     = owner;
    pick_vld = 1'b0;
    if (lock) begin
      pick_vld = req_valid[owner];
    end else begin
      for (int k = 1; k <= NCLI; k++) begin
        idx = PW'((int'(rr_ptr) + k) % NCLI);
        if (!pick_vld && req_valid[idx]) begin
          pick     = idx;
          pick_vld = 1'b1;
        end
      end
    end
  end

  assign take    = (state == IDLE) && pick_vld && !reset;
  assign tx_wr   = (state == ISSUE) && !tx_busy && !reset;
  assign tx_data = data_q;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[pick] = 1'b1;
  end

  always_comb begin
    grant = '0;
    if (lock || state != IDLE) grant[owner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    data_nxt  = data_q;
    case (state)
      IDLE: begin
        if (take) begin
          owner_nxt = pick;
          data_nxt  = req_data[8*pick +: 8];
          if (req_last[pick]) begin
            lock_nxt = 1'b0;
            rr_nxt   = pick;
          end else begin
            lock_nxt = 1'b1;
          end
          state_nxt = ISSUE;
        end else if (to_fire) begin
          lock_nxt = 1'b0;
          rr_nxt   = owner;
        end
      end
      ISSUE:     if (!tx_busy) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lock   <= 1'b0;
      owner  <= '0;
      rr_ptr <= PW'(NCLI - 1);
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      lock   <= lock_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      data_q <= data_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;
  logic          stall;
  logic          err_q;

  // Counts only idle cycles where a locked owner has nothing to offer.
  assign stall       = (state == IDLE) && lock && !req_valid[owner];
  assign to_fire     = stall && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (take || to_fire) to_cnt <= '0;
      else if (stall)      to_cnt <= to_cnt + 1'b1;
      if (to_fire) err_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign to_fire            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-cycle vector table, then client/UART models for packet, stall, reset and lock-timeout sequences.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        timeout_err;

  uart_tx_arb #(.NCLI(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_wr(tx_wr), .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       busy;
    logic [3:0] rdy;
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  localparam int BUSY_LEN = 3;
  int         busy_left = 0, hold_left = 0;
  bit         pending_wr = 0, hold_now = 0, hold_arm = 0, pkt_arm = 0, pkt_watch = 0;
  int         cyc = 0, hs_cyc = 0, wr_cyc = 0;
  int         rdy_bad = 0, wr_busy_bad = 0, hold_wr_bad = 0, hold_dat_bad = 0, pkt_bad = 0;
  logic [7:0] out_log[$];
  logic [8:0] cbuf[4][32];
  int         cwr[4], crd[4];

  task automatic add(input logic [3:0] vld, input logic busy, input logic [3:0] rdy,
                     input logic [3:0] gnt, input logic wr, input logic [7:0] dat);
    vec_t v;
    v.vld = vld; v.busy = busy; v.rdy = rdy; v.gnt = gnt; v.wr = wr; v.dat = dat;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input int c, input logic [8:0] v);
    cbuf[c][cwr[c]] = v;
    cwr[c]++;
  endtask

  function automatic logic [31:0] logv(input int k);
    return (k < out_log.size()) ? {24'h0, out_log[k]} : 32'hDEAD;
  endfunction

  // One clock of client + UART models: drive on negedge, sample 1 ns later.
  task automatic tick(input logic rst);
    @(negedge clk);
    reset = rst;
    if (pending_wr) begin
      busy_left  = BUSY_LEN;
      pending_wr = 0;
    end
    hold_now = (hold_left != 0);
    tx_busy  = (busy_left != 0) || (hold_left != 0);
    if (busy_left != 0) busy_left--;
    if (hold_left != 0) hold_left--;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (crd[i] != cwr[i]);
      req_data[8*i +: 8] = cbuf[i][crd[i]][7:0];
      req_last[i]        = cbuf[i][crd[i]][8];
    end
    #1;
    cyc++;
    if (((req_ready & (req_ready - 4'd1)) != 4'd0) || ((req_ready & ~req_valid) != 4'd0)) rdy_bad++;
    if (hold_now) begin
      if (tx_wr) hold_wr_bad++;
      if (tx_data !== 8'h77) hold_dat_bad++;
    end
    if (pkt_watch) begin
      if (grant !== 4'b0100) pkt_bad++;
      if (tx_wr && tx_data == 8'h33) pkt_watch = 0;
    end
    if (tx_wr) begin
      if (tx_busy) wr_busy_bad++;
      out_log.push_back(tx_data);
      pending_wr = 1;
      wr_cyc     = cyc;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        crd[i]++;
        if (i == 2 && pkt_arm) begin
          pkt_watch = 1;
          pkt_arm   = 0;
        end
        if (hold_arm) begin
          hold_left = 20;
          hold_arm  = 0;
          hs_cyc    = cyc;
        end
      end
    end
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (out_log.size() < n && b < budget) begin
      tick(1'b0);
      b++;
    end
    n_cmp++;
    if (out_log.size() < n) begin
      n_fail++;
      $display("FAIL %s: timed out with %0d bytes, %0d required", name, out_log.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      cwr[i] = 0;
      crd[i] = 0;
      for (int j = 0; j < 32; j++) cbuf[i][j] = '0;
    end
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);

    //   vld   busy rdy  gnt  wr dat
    add(4'h0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(4'hF, 0, 4'h1, 4'h0, 0, 8'h00);
    add(4'hF, 0, 4'h0, 4'h1, 1, 8'hA0);
    add(4'hF, 1, 4'h0, 4'h1, 0, 8'hA0);
    add(4'hF, 1, 4'h0, 4'h1, 0, 8'hA0);
    add(4'hF, 0, 4'h0, 4'h1, 0, 8'hA0);
    add(4'hF, 0, 4'h2, 4'h0, 0, 8'hA0);
    add(4'hF, 1, 4'h0, 4'h2, 0, 8'hA1);
    add(4'hF, 0, 4'h0, 4'h2, 1, 8'hA1);
    add(4'hF, 1, 4'h0, 4'h2, 0, 8'hA1);
    add(4'hF, 0, 4'h0, 4'h2, 0, 8'hA1);
    add(4'hF, 0, 4'h4, 4'h0, 0, 8'hA1);
    add(4'hF, 0, 4'h0, 4'h4, 1, 8'hA2);
    add(4'hF, 1, 4'h0, 4'h4, 0, 8'hA2);
    add(4'hF, 0, 4'h0, 4'h4, 0, 8'hA2);
    add(4'hF, 0, 4'h8, 4'h0, 0, 8'hA2);
    add(4'hF, 0, 4'h0, 4'h8, 1, 8'hA3);
    add(4'hF, 1, 4'h0, 4'h8, 0, 8'hA3);
    add(4'hF, 0, 4'h0, 4'h8, 0, 8'hA3);
    add(4'hF, 0, 4'h1, 4'h0, 0, 8'hA3);
    add(4'hF, 0, 4'h0, 4'h1, 1, 8'hA0);
    add(4'hF, 1, 4'h0, 4'h1, 0, 8'hA0);
    add(4'hF, 0, 4'h0, 4'h1, 0, 8'hA0);
    add(4'h0, 0, 4'h0, 4'h0, 0, 8'hA0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset     = 1'b0;
      req_valid = tbl[i].vld;
      tx_busy   = tbl[i].busy;
      req_data  = 32'hA3A2A1A0;
      req_last  = 4'hF;
      #1;
      chk($sformatf("tbl%0d_rdy", i),   {28'h0, req_ready}, {28'h0, tbl[i].rdy});
      chk($sformatf("tbl%0d_grant", i), {28'h0, grant},     {28'h0, tbl[i].gnt});
      chk($sformatf("tbl%0d_wr", i),    {31'h0, tx_wr},     {31'h0, tbl[i].wr});
      chk($sformatf("tbl%0d_data", i),  {24'h0, tx_data},   {24'h0, tbl[i].dat});
    end
    chk("reset_timeout_err", {31'h0, timeout_err}, 32'h0);

    // Client 2 packet while client 0 waits.
    out_log.delete();
    push(2, 9'h011); push(2, 9'h022); push(2, 9'h133);
    push(0, 9'h155);
    pkt_arm = 1;
    run_until(4, 200, "pkt_run");
    chk("pkt_b0", logv(0), 32'h11);
    chk("pkt_b1", logv(1), 32'h22);
    chk("pkt_b2", logv(2), 32'h33);
    chk("pkt_c0", logv(3), 32'h55);
    chk("pkt_grant_bad_cycles", pkt_bad, 0);
    chk("pkt_window_closed", {31'h0, pkt_watch}, 32'h0);

    // UART busy held for 20 cycles after ISSUE entry.
    out_log.delete();
    push(1, 9'h177);
    hold_arm = 1;
    run_until(1, 100, "stall_run");
    chk("stall_wr_delay", wr_cyc - hs_cyc, 21);
    chk("stall_wr_during_busy", hold_wr_bad, 0);
    chk("stall_data_unstable", hold_dat_bad, 0);
    chk("stall_byte", logv(0), 32'h77);
    repeat (6) tick(1'b0);
    chk("stall_single_pulse", out_log.size(), 1);
    chk("stall_idle_grant", {28'h0, grant}, 32'h0);

    // Reset during WAIT_DONE with client 3 locked mid-packet.
    out_log.delete();
    push(3, 9'h099); push(3, 9'h19A);
    run_until(1, 100, "rst_run");
    tick(1'b0);
    chk("rst_pre_grant", {28'h0, grant}, 32'h8);
    tick(1'b1);
    push(0, 9'h1C0);
    tick(1'b0);
    chk("rst_post_grant", {28'h0, grant}, 32'h0);
    chk("rst_post_wr", {31'h0, tx_wr}, 32'h0);
    chk("rst_post_rdy", {28'h0, req_ready}, 32'h1);
    run_until(3, 200, "rst_drain");
    chk("rst_b0", logv(0), 32'h99);
    chk("rst_b1", logv(1), 32'hC0);
    chk("rst_b2", logv(2), 32'h9A);

    // Client 1 stalls mid-packet while client 2 waits.
    out_log.delete();
    push(1, 9'h0D1);
    push(2, 9'h1E2);
    run_until(1, 100, "to_run");
    chk("to_first", logv(0), 32'hD1);
    chk("to_err_early", {31'h0, timeout_err}, 32'h0);
    repeat (60) tick(1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_err_set", {31'h0, timeout_err}, 32'h1);
    chk("to_count", out_log.size(), 2);
    chk("to_c2_served", logv(1), 32'hE2);
    chk("to_grant_free", {28'h0, grant}, 32'h0);
`else
    chk("to_grant_held", {28'h0, grant}, 32'h2);
    chk("to_count", out_log.size(), 1);
    chk("to_err_zero", {31'h0, timeout_err}, 32'h0);
    chk("to_rdy_none", {28'h0, req_ready}, 32'h0);
`endif

    chk("rdy_onehot_violations", rdy_bad, 0);
    chk("wr_while_busy", wr_busy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NCLI, 4, number of byte-stream clients; fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT_CYCLES, 1000000, grant-watchdog limit in clk cycles; used only with UART_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  4  per-client byte-valid.
REQ-006 req_data  input  32  packed client bytes; client i is bits [8i+7:8i].
REQ-007 req_last  input  4  per-client end-of-packet flag, qualified by req_valid.
REQ-008 req_ready  output  4  per-client byte-accept strobe.
REQ-009 grant  output  4  one-hot current owner; 0 when no owner.
REQ-010 tx_data  output  8  byte to UART transmitter.
REQ-011 tx_wr  output  1  UART write strobe.
REQ-012 tx_busy  input  1  UART transmitter busy.
REQ-013 timeout_err  output  1  sticky watchdog flag.

Function
REQ-014 Transfer on client i SHALL occur in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE, unlocked: SHALL pick the first valid client scanning round-robin from rr_ptr+1 mod 4, assert its req_ready combinationally that cycle, capture the byte, then go to ISSUE.
REQ-017 IDLE, locked: SHALL consider only the owner; other clients SHALL see req_ready=0.
REQ-018 Accepting a byte with req_last=0 SHALL set lock; with req_last=1 it SHALL clear lock and set rr_ptr to the owner index.
REQ-019 ISSUE: tx_wr SHALL be 1 exactly one cycle, in the first ISSUE cycle with tx_busy=0; tx_data SHALL hold the captured byte; then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; WAIT_DONE: on tx_busy=0 go to IDLE.
REQ-021 Minimum byte-to-byte overhead SHALL be IDLE->ISSUE->WAIT_BUSY->WAIT_DONE->IDLE; the next req_ready SHALL come no earlier than the cycle after tx_busy falls.
REQ-022 grant SHALL be one-hot owner while locked or in ISSUE/WAIT_BUSY/WAIT_DONE, else 0.
REQ-023 At most one req_ready bit SHALL be 1 in any cycle; req_ready SHALL be 0 outside IDLE.
REQ-024 Single-byte packet (req_last=1 on first byte) SHALL release arbitration after that byte.
REQ-025 Valid from a non-owner while locked SHALL wait, not be dropped; after release it SHALL be served by round-robin order.
REQ-026 rr_ptr wrap: 3+1 SHALL scan from client 0.

Reset
REQ-027 Reset SHALL force IDLE, lock=0, rr_ptr=3 (so client 0 wins first), tx_wr=0, tx_data=0, req_ready=0, grant=0, timeout_err=0.
REQ-028 Reset mid-operation SHALL abandon the captured byte and any packet lock without further tx_wr.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined: a counter SHALL count cycles in IDLE while locked with req_valid[owner]=0; reaching TIMEOUT_CYCLES SHALL clear lock, set rr_ptr to the owner, and set timeout_err, which holds until reset; any owner transfer clears the counter.
REQ-030 Macro undefined: no counter; lock SHALL persist indefinitely; timeout_err SHALL be constant 0.

Verification
REQ-031 After reset, req_valid=4'b1111, all req_last=1, bytes 0xA0..0xA3 -> tx_wr bytes in order 0xA0,0xA1,0xA2,0xA3; each tx_wr only while tx_busy=0.
REQ-032 Client 2 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33) while client 0 valid -> UART sees 0x11,0x22,0x33, then client 0's byte; grant=4'b0100 throughout the packet.
REQ-033 tx_busy held high on ISSUE entry for 20 cycles -> tx_wr stays 0, then pulses once after tx_busy=0; tx_data stable.
REQ-034 Reset asserted in WAIT_DONE with lock set -> next cycle grant=0, tx_wr=0; after release client 0 wins.
REQ-035 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, owner 1 stalls mid-packet -> after 16 cycles lock cleared, timeout_err=1, client 2 served next; without macro, grant stays 4'b0010.
